// File: rtl/ucsbece154b_bp_ctrl_if.sv
// Resolved control-flow record handshake from Execute into the branch predictor sequencer.
interface ucsbece154b_bp_ctrl_if #(
   parameter int NUM_GHR_BITS = 5
);
   logic                    res_valid;
   logic                    res_ready;
   logic [31:0]             res_pc;
   logic [31:0]             res_target;
   logic [6:0]              res_op;
   logic                    res_taken;
   logic                    res_mispredict;
   logic                    res_btbhit;
   logic [NUM_GHR_BITS-1:0] res_phtaddr;

   modport master (
      output res_valid, res_pc, res_target, res_op, res_taken,
             res_mispredict, res_btbhit, res_phtaddr,
      input  res_ready
   );

   modport slave (
      input  res_valid, res_pc, res_target, res_op, res_taken,
             res_mispredict, res_btbhit, res_phtaddr,
      output res_ready
   );
endinterface

// File: rtl/ucsbece154b_bp_ctrl.sv
// Branch predictor sequencer: sweeps BTB/PHT clear after reset, queues resolved records
// from Execute and drains one per cycle into the predictor write ports.
module ucsbece154b_bp_ctrl #(
   parameter int NUM_BTB_ENTRIES = 32,
   parameter int NUM_GHR_BITS    = 5,
   parameter int FIFO_DEPTH      = 2,
   parameter int RECOVER_CYCLES  = 2,
   localparam int BI = $clog2(NUM_BTB_ENTRIES),
   localparam int G  = NUM_GHR_BITS
) (
   input  logic                 clk,
   input  logic                 reset_i,
   ucsbece154b_bp_ctrl_if.slave res,
   output logic [BI-1:0]        BTBwriteaddress_o,
   output logic [31:0]          BTBwritedata_o,
   output logic                 BTBclear_o,
   output logic                 BTB_we_o,
   output logic [G-1:0]         PHTwriteaddress_o,
   output logic                 PHTincrement_o,
   output logic                 PHTinit_o,
   output logic                 PHTwe_o,
   output logic                 GHRreset_o,
   output logic                 flush_o,
   output logic                 busy_o,
   output logic [15:0]          mispredict_cnt_o
);
   localparam int PHT_N   = 1 << G;
   localparam int SWEEP_N = (NUM_BTB_ENTRIES > PHT_N) ? NUM_BTB_ENTRIES : PHT_N;
   localparam int IW      = $clog2(SWEEP_N);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int RW      = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

   localparam logic [IW-1:0] IDX_LAST  = IW'(SWEEP_N - 1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [RW-1:0] RC_LAST   = RW'(RECOVER_CYCLES - 1);
   localparam logic [RW-1:0] RC_ONE    = RW'(1);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      INIT    = 2'd0,
      RUN     = 2'd1,
      RECOVER = 2'd2
   } state_e;

   // Records are decoded on entry so the queue holds only what the write rules need.
   typedef struct packed {
      logic [BI-1:0] btb_idx;
      logic [31:0]   target;
      logic          is_branch;
      logic          is_jump;
      logic          taken;
      logic          mispredict;
      logic          btbhit;
      logic [G-1:0]  phtaddr;
   } rec_t;

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [RW-1:0] rc_q, rc_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   rec_t          mem_q [FIFO_DEPTH];
   rec_t          mem_d [FIFO_DEPTH];

   logic [BI-1:0] btb_addr_q, btb_addr_d;
   logic [31:0]   btb_data_q, btb_data_d;
   logic          btb_clear_q, btb_clear_d, btb_we_q, btb_we_d;
   logic [G-1:0]  pht_addr_q, pht_addr_d;
   logic          pht_inc_q, pht_inc_d, pht_init_q, pht_init_d, pht_we_q, pht_we_d;
   logic          ghr_reset_q, ghr_reset_d, flush_q, flush_d;
   logic          ready_q, ready_d, busy_q, busy_d;
   logic [15:0]   mispredict_cnt_q, mispredict_cnt_d;

   rec_t rec_in_s, head_s;
   logic push_s, pop_s;

   assign rec_in_s.btb_idx    = res.res_pc[BI+1:2];
   assign rec_in_s.target     = res.res_target;
   assign rec_in_s.is_branch  = (res.res_op == OP_BRANCH);
   assign rec_in_s.is_jump    = (res.res_op == OP_JAL) || (res.res_op == OP_JALR);
   assign rec_in_s.taken      = res.res_taken;
   assign rec_in_s.mispredict = res.res_mispredict;
   assign rec_in_s.btbhit     = res.res_btbhit;
   assign rec_in_s.phtaddr    = res.res_phtaddr;

   // Next-state, queue bookkeeping and next values of every registered output.
   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      rc_d             = rc_q;
      wr_ptr_d         = wr_ptr_q;
      rd_ptr_d         = rd_ptr_q;
      count_d          = count_q;
      mem_d            = mem_q;
      mispredict_cnt_d = mispredict_cnt_q;
      btb_addr_d       = '0;
      btb_data_d       = 32'h0000_0000;
      btb_clear_d      = 1'b0;
      btb_we_d         = 1'b0;
      pht_addr_d       = '0;
      pht_inc_d        = 1'b0;
      pht_init_d       = 1'b0;
      pht_we_d         = 1'b0;
      ghr_reset_d      = 1'b0;
      flush_d          = 1'b0;
      head_s           = mem_q[rd_ptr_q];
      push_s           = res.res_valid & ready_q;
      pop_s            = (state_q == RUN) && (count_q != '0);

      case (state_q)
         INIT: begin
            if (int'(idx_q) < NUM_BTB_ENTRIES) begin
               btb_we_d    = 1'b1;
               btb_clear_d = 1'b1;
               btb_addr_d  = idx_q[BI-1:0];
            end else begin
               btb_we_d    = 1'b0;
            end
            if (int'(idx_q) < PHT_N) begin
               pht_we_d    = 1'b1;
               pht_init_d  = 1'b1;
               pht_addr_d  = idx_q[G-1:0];
            end else begin
               pht_we_d    = 1'b0;
            end
            if (idx_q == IDX_LAST) begin
               ghr_reset_d = 1'b1;
               idx_d       = '0;
               state_d     = RUN;
            end else begin
               idx_d       = idx_q + IDX_ONE;
            end
         end
         RUN: begin
            if (push_s) begin
               mem_d[wr_ptr_q] = rec_in_s;
               wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
               wr_ptr_d        = wr_ptr_q;
            end
            if (pop_s) begin
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               if (head_s.is_branch) begin
                  pht_we_d   = 1'b1;
                  pht_addr_d = head_s.phtaddr;
                  pht_inc_d  = head_s.taken;
               end else begin
                  pht_we_d   = 1'b0;
               end
               if ((head_s.is_jump || (head_s.is_branch && head_s.taken)) &&
                   (!head_s.btbhit || head_s.mispredict)) begin
                  btb_we_d   = 1'b1;
                  btb_addr_d = head_s.btb_idx;
                  btb_data_d = head_s.target;
               end else begin
                  btb_we_d   = 1'b0;
               end
            end else begin
               rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
               2'b10:   count_d = count_q + CNT_ONE;
               2'b01:   count_d = count_q - CNT_ONE;
               default: count_d = count_q;
            endcase
            // Everything queued behind a mispredicted record is wrong-path work.
            if (pop_s && head_s.mispredict) begin
               flush_d     = 1'b1;
               ghr_reset_d = 1'b1;
               count_d     = '0;
               wr_ptr_d    = '0;
               rd_ptr_d    = '0;
               rc_d        = '0;
               state_d     = RECOVER;
               mispredict_cnt_d = (mispredict_cnt_q == 16'hFFFF) ? mispredict_cnt_q
                                                                 : mispredict_cnt_q + 16'd1;
            end else begin
               state_d     = RUN;
            end
         end
         RECOVER: begin
            if (rc_q == RC_LAST) begin
               rc_d    = '0;
               state_d = RUN;
            end else begin
               rc_d    = rc_q + RC_ONE;
            end
         end
         default: begin
            state_d = INIT;
            idx_d   = '0;
         end
      endcase

      ready_d = (state_d == RUN) && (count_d != FIFO_FULL);
      busy_d  = (state_d != RUN);
   end

   // State, queue and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset_i) begin
         state_q          <= INIT;
         idx_q            <= '0;
         rc_q             <= '0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         mispredict_cnt_q <= 16'h0000;
         btb_addr_q       <= '0;
         btb_data_q       <= 32'h0000_0000;
         btb_clear_q      <= 1'b0;
         btb_we_q         <= 1'b0;
         pht_addr_q       <= '0;
         pht_inc_q        <= 1'b0;
         pht_init_q       <= 1'b0;
         pht_we_q         <= 1'b0;
         ghr_reset_q      <= 1'b0;
         flush_q          <= 1'b0;
         ready_q          <= 1'b0;
         busy_q           <= 1'b1;
      end else begin
         state_q          <= state_d;
         idx_q            <= idx_d;
         rc_q             <= rc_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         mispredict_cnt_q <= mispredict_cnt_d;
         btb_addr_q       <= btb_addr_d;
         btb_data_q       <= btb_data_d;
         btb_clear_q      <= btb_clear_d;
         btb_we_q         <= btb_we_d;
         pht_addr_q       <= pht_addr_d;
         pht_inc_q        <= pht_inc_d;
         pht_init_q       <= pht_init_d;
         pht_we_q         <= pht_we_d;
         ghr_reset_q      <= ghr_reset_d;
         flush_q          <= flush_d;
         ready_q          <= ready_d;
         busy_q           <= busy_d;
      end
   end

   assign res.res_ready       = ready_q;
   assign BTBwriteaddress_o   = btb_addr_q;
   assign BTBwritedata_o      = btb_data_q;
   assign BTBclear_o          = btb_clear_q;
   assign BTB_we_o            = btb_we_q;
   assign PHTwriteaddress_o   = pht_addr_q;
   assign PHTincrement_o      = pht_inc_q;
   assign PHTinit_o           = pht_init_q;
   assign PHTwe_o             = pht_we_q;
   assign GHRreset_o          = ghr_reset_q;
   assign flush_o             = flush_q;
   assign busy_o              = busy_q;
   assign mispredict_cnt_o    = mispredict_cnt_q;
endmodule

// File: tb/tb_ucsbece154b_bp_ctrl.sv
// Bench for ucsbece154b_bp_ctrl: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the sequencer rules.
module tb_ucsbece154b_bp_ctrl;
   localparam int NB = 32, G = 5, DEPTH = 2, RC = 2, BI = 5, SWEEP = 32;
   localparam int M_INIT = 0, M_RUN = 1, M_REC = 2;
   localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111, OP_ALU = 7'b0110011;

   typedef struct {
      logic [31:0]  pc;
      logic [31:0]  target;
      logic [6:0]   op;
      logic         taken;
      logic         misp;
      logic         hit;
      logic [G-1:0] pht;
   } rec_t;

   logic clk = 1'b0;
   logic reset_i;
   always #5 clk = ~clk;

   ucsbece154b_bp_ctrl_if #(.NUM_GHR_BITS(G)) res_if ();

   logic [BI-1:0] btb_addr;
   logic [31:0]   btb_data;
   logic          btb_clear, btb_we, pht_inc, pht_init, pht_we, ghr_reset, flush, busy;
   logic [G-1:0]  pht_addr;
   logic [15:0]   mcnt;

   ucsbece154b_bp_ctrl #(
      .NUM_BTB_ENTRIES(NB), .NUM_GHR_BITS(G), .FIFO_DEPTH(DEPTH), .RECOVER_CYCLES(RC)
   ) dut (
      .clk(clk), .reset_i(reset_i), .res(res_if),
      .BTBwriteaddress_o(btb_addr), .BTBwritedata_o(btb_data), .BTBclear_o(btb_clear),
      .BTB_we_o(btb_we), .PHTwriteaddress_o(pht_addr), .PHTincrement_o(pht_inc),
      .PHTinit_o(pht_init), .PHTwe_o(pht_we), .GHRreset_o(ghr_reset), .flush_o(flush),
      .busy_o(busy), .mispredict_cnt_o(mcnt)
   );

   int n_assert = 0, n_fail = 0;
   int m_mode = M_INIT, m_sweep = 0, m_rec_left = 0, m_cnt = 0;
   rec_t m_q[$];
   int e_btb_we, e_btb_addr, e_btb_clear, e_pht_we, e_pht_addr, e_pht_inc, e_pht_init;
   int e_ghr, e_flush, e_busy;
   int e_ready = 0;
   logic [31:0] e_btb_data;
   rec_t cur;
   bit cur_valid = 1'b0, last_hs = 1'b0, dut_hs = 1'b0;
   int flush_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input bit v, input rec_t r);
      cur = r;
      cur_valid = v;
      res_if.res_valid      = v;
      res_if.res_pc         = r.pc;
      res_if.res_target     = r.target;
      res_if.res_op         = r.op;
      res_if.res_taken      = r.taken;
      res_if.res_mispredict = r.misp;
      res_if.res_btbhit     = r.hit;
      res_if.res_phtaddr    = r.pht;
   endtask

   function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] tgt,
                               input logic [6:0] op, input bit tk, input bit mp,
                               input bit hit, input int pht);
      rec_t r;
      r.pc = pc; r.target = tgt; r.op = op; r.taken = tk;
      r.misp = mp; r.hit = hit; r.pht = G'(pht);
      return r;
   endfunction

   function automatic rec_t rnd_rec();
      rec_t r;
      int k;
      k = int'($urandom_range(0, 3));
      r.pc     = $urandom & 32'hFFFF_FFFC;
      r.target = $urandom & 32'hFFFF_FFFC;
      r.op     = (k == 0) ? OP_BR : (k == 1) ? OP_JAL : (k == 2) ? OP_JALR : OP_ALU;
      r.taken  = (k == 1 || k == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      r.misp   = ($urandom_range(0, 7) == 0);
      r.hit    = 1'($urandom_range(0, 1));
      r.pht    = G'($urandom_range(0, (1 << G) - 1));
      return r;
   endfunction

   // One clock: predict the outputs after the coming edge, then compare them.
   task automatic tick();
      rec_t h;
      bit accept;
      dut_hs = cur_valid && (res_if.res_ready === 1'b1);
      last_hs = cur_valid && (e_ready != 0);
      accept = last_hs;
      e_btb_we = 0; e_btb_addr = 0; e_btb_clear = 0; e_btb_data = 32'h0;
      e_pht_we = 0; e_pht_addr = 0; e_pht_inc = 0; e_pht_init = 0; e_ghr = 0; e_flush = 0;
      if (reset_i) begin
         m_mode = M_INIT; m_sweep = 0; m_cnt = 0; m_q.delete();
      end else if (m_mode == M_INIT) begin
         if (m_sweep < NB) begin e_btb_we = 1; e_btb_clear = 1; e_btb_addr = m_sweep; end
         if (m_sweep < (1 << G)) begin e_pht_we = 1; e_pht_init = 1; e_pht_addr = m_sweep; end
         if (m_sweep == SWEEP - 1) begin e_ghr = 1; m_mode = M_RUN; end
         m_sweep++;
      end else if (m_mode == M_RUN) begin
         if (m_q.size() > 0) begin
            h = m_q.pop_front();
            if (h.op == OP_BR) begin e_pht_we = 1; e_pht_addr = int'(h.pht); e_pht_inc = int'(h.taken); end
            if ((h.op == OP_JAL || h.op == OP_JALR || (h.op == OP_BR && h.taken)) && (!h.hit || h.misp)) begin
               e_btb_we = 1; e_btb_data = h.target; e_btb_addr = int'((h.pc >> 2) % NB);
            end
            if (h.misp) begin
               e_flush = 1; e_ghr = 1;
               if (m_cnt < 65535) m_cnt++;
               m_q.delete(); accept = 1'b0; m_mode = M_REC; m_rec_left = RC;
            end
         end
         if (accept) m_q.push_back(cur);
      end else begin
         m_rec_left--;
         if (m_rec_left == 0) m_mode = M_RUN;
      end
      e_ready = (m_mode == M_RUN && m_q.size() < DEPTH) ? 1 : 0;
      e_busy = (m_mode != M_RUN) ? 1 : 0;
      @(posedge clk);
      #1;
      if (flush === 1'b1) flush_seen++;
      chk("ready", 32'(res_if.res_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("btb_we", 32'(btb_we), 32'(e_btb_we));
      chk("pht_we", 32'(pht_we), 32'(e_pht_we));
      chk("ghr_reset", 32'(ghr_reset), 32'(e_ghr));
      chk("flush", 32'(flush), 32'(e_flush));
      chk("mispredict_cnt", 32'(mcnt), 32'(m_cnt));
      if (e_btb_we != 0) begin
         chk("btb_addr", 32'(btb_addr), 32'(e_btb_addr));
         chk("btb_clear", 32'(btb_clear), 32'(e_btb_clear));
         if (e_btb_clear == 0) chk("btb_data", btb_data, e_btb_data);
      end
      if (e_pht_we != 0) begin
         chk("pht_addr", 32'(pht_addr), 32'(e_pht_addr));
         chk("pht_init", 32'(pht_init), 32'(e_pht_init));
         if (e_pht_init == 0) chk("pht_inc", 32'(pht_inc), 32'(e_pht_inc));
      end
   endtask

   task automatic xfer(input rec_t r);
      int k;
      send(1'b1, r);
      k = 0;
      do begin
         tick();
         k++;
      end while (!dut_hs && k < 20);
      chk("accept_in_time", 32'(dut_hs), 32'd1);
      send(1'b0, r);
   endtask

   initial begin
      rec_t r;
      int base;
      reset_i = 1'b1;
      send(1'b0, mk(32'h0, 32'h0, OP_ALU, 1'b0, 1'b0, 1'b0, 0));
      tick();
      reset_i = 1'b0;

      // Post-reset sweep while Execute already offers a jal that must wait.
      send(1'b1, mk(32'h0000_0100, 32'h0000_0080, OP_JAL, 1'b1, 1'b0, 1'b0, 0));
      repeat (SWEEP) tick();
      tick();
      send(1'b0, cur);

      // Taken beq into an empty BTB slot.
      xfer(mk(32'h0000_0040, 32'h0000_0020, OP_BR, 1'b1, 1'b0, 1'b0, 5));
      repeat (3) tick();

      // Back-to-back records with a mispredict at the head.
      base = flush_seen;
      xfer(mk(32'h0000_0200, 32'h0000_0300, OP_BR, 1'b1, 1'b1, 1'b1, 9));
      xfer(mk(32'h0000_0204, 32'h0000_0400, OP_JAL, 1'b1, 1'b0, 1'b0, 0));
      xfer(mk(32'h0000_0208, 32'h0000_0500, OP_BR, 1'b0, 1'b0, 1'b0, 3));
      repeat (3) tick();
      chk("flush_pulses", 32'(flush_seen - base), 32'd1);
      chk("cnt_after_misp", 32'(mcnt), 32'd1);

      // Streaming: push and pop every cycle, order must hold.
      xfer(mk(32'h0000_1000, 32'h0000_0A00, OP_JALR, 1'b1, 1'b0, 1'b0, 0));
      xfer(mk(32'h0000_1004, 32'h0000_0B00, OP_BR, 1'b1, 1'b0, 1'b1, 17));
      xfer(mk(32'h0000_1008, 32'h0000_0C00, OP_ALU, 1'b0, 1'b0, 1'b0, 0));
      xfer(mk(32'h0000_100C, 32'h0000_0D00, OP_JAL, 1'b1, 1'b0, 1'b0, 0));
      repeat (3) tick();

      // Reset mid-sweep, then reset during recovery with work queued.
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      repeat (10) tick();
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      repeat (SWEEP + 1) tick();
      xfer(mk(32'h0000_2000, 32'h0000_2100, OP_JAL, 1'b1, 1'b1, 1'b1, 0));
      send(1'b1, mk(32'h0000_2004, 32'h0000_2200, OP_BR, 1'b1, 1'b0, 1'b0, 2));
      tick();
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      send(1'b0, cur);
      repeat (SWEEP + 2) tick();
      chk("cnt_after_reset", 32'(mcnt), 32'd0);

      // Counter saturation from a preloaded value.
      force dut.mispredict_cnt_q = 16'hFFFE;
      #1;
      release dut.mispredict_cnt_q;
      m_cnt = 65534;
      tick();
      xfer(mk(32'h0000_3000, 32'h0000_3100, OP_BR, 1'b0, 1'b1, 1'b0, 7));
      repeat (4) tick();
      xfer(mk(32'h0000_3004, 32'h0000_3200, OP_JALR, 1'b1, 1'b1, 1'b1, 0));
      repeat (4) tick();
      chk("cnt_saturated", 32'(mcnt), 32'h0000_FFFF);

      // Random traffic; an offered record is held until it is taken.
      for (int i = 0; i < 600; i++) begin
         if (!cur_valid || dut_hs) begin
            r = rnd_rec();
            send($urandom_range(0, 3) != 0, r);
         end
         tick();
      end
      send(1'b0, cur);
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
